// File: rtl/nes_pkg.sv
// Shared NES definitions: OAM DMA state encoding and default register addresses.
// Imported by the OAM DMA engine and by anything that needs the same map.
package nes_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_HALT,
        ST_ALIGN,
        ST_READ,
        ST_WRITE
    } dma_state_e;

    localparam logic [15:0] DMA_REG_ADDR_DEF  = 16'h4014;
    localparam logic [15:0] OAM_DATA_ADDR_DEF = 16'h2004;

endpackage

// File: rtl/oam_dma.sv
// OAM DMA engine: a CPU write to DMA_REG_ADDR halts the CPU and copies
// 256 bytes from {page,00..FF} to OAM_DATA_ADDR, one read + one write each.
// Ports: clk, rst (async, active-high); cpu_addr/cpu_d_out/cpu_write (CPU
// request); bus_d_in (bus read data); bus_addr/bus_d_out/bus_write (muxed
// bus); rdy (CPU may advance); dma_active (DMA owns the bus).
module oam_dma
    import nes_pkg::*;
#(
    parameter logic [15:0] DMA_REG_ADDR  = DMA_REG_ADDR_DEF,
    parameter logic [15:0] OAM_DATA_ADDR = OAM_DATA_ADDR_DEF
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] cpu_addr,
    input  logic [7:0]  cpu_d_out,
    input  logic        cpu_write,
    input  logic [7:0]  bus_d_in,
    output logic [15:0] bus_addr,
    output logic [7:0]  bus_d_out,
    output logic        bus_write,
    output logic        rdy,
    output logic        dma_active
);

    dma_state_e state_q, state_d;
    logic [7:0] page_q, page_d;
    logic [7:0] index_q, index_d;
    logic [7:0] data_q, data_d;
    logic       parity_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            page_q   <= 8'h00;
            index_q  <= 8'h00;
            data_q   <= 8'h00;
            parity_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            page_q   <= page_d;
            index_q  <= index_d;
            data_q   <= data_d;
            parity_q <= ~parity_q;
        end
    end

    always_comb begin
        state_d    = state_q;
        page_d     = page_q;
        index_d    = index_q;
        data_d     = data_q;
        bus_addr   = cpu_addr;
        bus_d_out  = cpu_d_out;
        bus_write  = cpu_write;
        rdy        = 1'b1;
        dma_active = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                // The trigger write itself still reaches the bus.
                if (cpu_write && (cpu_addr == DMA_REG_ADDR)) begin
                    page_d  = cpu_d_out;
                    index_d = 8'h00;
                    state_d = ST_HALT;
                end
            end
            ST_HALT: begin
                bus_write  = 1'b0;
                rdy        = 1'b0;
                dma_active = 1'b1;
                // An odd cycle here costs one extra alignment cycle.
                state_d    = parity_q ? ST_ALIGN : ST_READ;
            end
            ST_ALIGN: begin
                bus_write  = 1'b0;
                rdy        = 1'b0;
                dma_active = 1'b1;
                state_d    = ST_READ;
            end
            ST_READ: begin
                bus_addr   = {page_q, index_q};
                bus_d_out  = data_q;
                bus_write  = 1'b0;
                rdy        = 1'b0;
                dma_active = 1'b1;
                data_d     = bus_d_in;
                state_d    = ST_WRITE;
            end
            ST_WRITE: begin
                bus_addr   = OAM_DATA_ADDR;
                bus_d_out  = data_q;
                bus_write  = 1'b1;
                rdy        = 1'b0;
                dma_active = 1'b1;
                if (index_q == 8'hFF) begin
                    state_d = ST_IDLE;
                end else begin
                    index_d = index_q + 8'h01;
                    state_d = ST_READ;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

endmodule

// File: doc/oam_dma.md
OAM_DMA -- requirements
Module: oam_dma

Interface
REQ-001 SHALL have parameter DMA_REG_ADDR, default 16'h4014, meaning CPU write address that triggers a DMA.
REQ-002 SHALL have parameter OAM_DATA_ADDR, default 16'h2004, meaning destination address for every DMA write.
REQ-003 SHALL have port clk  input  1  system clock; one clock, all state on rising edge.
REQ-004 SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-005 SHALL have port cpu_addr  input  16  CPU address request.
REQ-006 SHALL have port cpu_d_out  input  8  CPU write data.
REQ-007 SHALL have port cpu_write  input  1  CPU write strobe.
REQ-008 SHALL have port bus_d_in  input  8  system-bus read data, valid combinationally in the same cycle as bus_addr.
REQ-009 SHALL have port bus_addr  output  16  muxed system-bus address.
REQ-010 SHALL have port bus_d_out  output  8  muxed system-bus write data.
REQ-011 SHALL have port bus_write  output  1  muxed system-bus write strobe.
REQ-012 SHALL have port rdy  output  1  high = CPU may advance; low = CPU holds PC and state.
REQ-013 SHALL have port dma_active  output  1  high while the bus is owned by the DMA.

Function
REQ-014 SHALL implement states IDLE, HALT, ALIGN, READ, WRITE.
REQ-015 SHALL keep a parity flop that toggles every cycle from reset value 0.
REQ-016 In IDLE: bus_addr=cpu_addr, bus_d_out=cpu_d_out, bus_write=cpu_write, rdy=1, dma_active=0.
REQ-017 In IDLE, a cycle with cpu_write=1 and cpu_addr=DMA_REG_ADDR SHALL pass through to the bus unchanged, latch page=cpu_d_out, clear index to 0, and go to HALT.
REQ-018 In HALT, ALIGN, READ, WRITE: rdy=0, dma_active=1, CPU inputs ignored.
REQ-019 In HALT and ALIGN: bus_write=0, bus_addr=cpu_addr.
REQ-020 HALT SHALL go to ALIGN if parity=1 in that cycle, else to READ.
REQ-021 ALIGN SHALL go to READ unconditionally.
REQ-022 READ: bus_addr={page,index}, bus_write=0; bus_d_in SHALL be captured into an 8-bit data register; next state WRITE.
REQ-023 WRITE: bus_addr=OAM_DATA_ADDR, bus_d_out=data register, bus_write=1.
REQ-024 WRITE with index<255 SHALL increment index and go to READ; with index=255 it SHALL go to IDLE, and index SHALL NOT wrap into a 257th transfer.
REQ-025 Latency: rdy low for exactly 513 cycles with even alignment, 514 with odd; rdy=1 in the cycle after the final WRITE.
REQ-026 Transfers SHALL be exactly 256, in ascending source order {page,8'h00}..{page,8'hFF}; page=8'hFF is legal.
REQ-027 Writes to DMA_REG_ADDR during a DMA SHALL be impossible, since the CPU is held; any such inputs SHALL be ignored.
REQ-028 CPU writes to any other address in IDLE SHALL NOT start a DMA.

Reset
REQ-029 rst=1 SHALL immediately force IDLE, page=0, index=0, data=0, parity=0.
REQ-030 During and after reset, outputs SHALL be: rdy=1, dma_active=0, bus signals passing the CPU signals through.
REQ-031 Reset mid-DMA SHALL abort without a further bus_write; after release the block SHALL wait for a new trigger.

Structure
REQ-032 The state enum and the DMA_REG_ADDR/OAM_DATA_ADDR defaults SHALL live in shared package nes_pkg.
REQ-033 The block SHALL be a single module with no sub-module; the output mux is combinational from state.

Verification
REQ-034 Trigger with even parity: write 8'h02 to 16'h4014, source 16'h0200+i holds i^8'hA5 -> 256 writes to 16'h2004 with data i^8'hA5, in order; rdy low 513 cycles.
REQ-035 Trigger with odd parity, page 8'h07 -> one ALIGN cycle; rdy low 514 cycles; first read address 16'h0700.
REQ-036 Page 8'hFF -> last read address 16'hFFFF, then IDLE with no 257th write.
REQ-037 Assert rst after 100 writes -> rdy=1 and bus_write follows cpu_write in the same cycle; a new trigger with 8'h03 restarts at 16'h0300.
REQ-038 CPU writes to 16'h4015 and 16'h2004 in IDLE -> no DMA; bus mirrors the CPU signals and rdy stays 1.
REQ-039 Scoreboard check across all scenarios: bus_write is never 1 in HALT, ALIGN or READ.
